// File: rtl/ysyx_24100029_pkg.sv
// Shared types for the IFU/LSU memory arbiter: bus opcodes, arbiter
// states and master identifiers.
package ysyx_24100029_pkg;

  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_READ  = 2'b01,
    OP_WRITE = 2'b10
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_GRANT_IFU = 2'b01,
    ST_GRANT_LSU = 2'b10
  } arb_state_e;

  typedef enum logic {
    M_IFU = 1'b0,
    M_LSU = 1'b1
  } master_e;

  // The reserved encoding 2'b11 counts as no request.
  function automatic logic op_valid(input logic [1:0] op);
    return (op == OP_READ) || (op == OP_WRITE);
  endfunction

endpackage

// File: rtl/ysyx_24100029_arb_pick.sv
// Winner selection between IFU and LSU requests.
// Macro YSYX_24100029_ARB_RR_EN: defined -> round-robin using a last_grant
// register; undefined -> fixed priority with LSU winning ties.
module ysyx_24100029_arb_pick
  import ysyx_24100029_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    ifu_req,
  input  logic    lsu_req,
  input  logic    grant_en,
  output master_e winner
);

`ifdef YSYX_24100029_ARB_RR_EN
  master_e last_grant;

  // Remember who was granted most recently; reset favours LSU on the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= M_IFU;
    end else if (grant_en) begin
      last_grant <= winner;
    end
  end

  // On a tie, the master that did not win last time goes next.
  always_comb begin
    winner = M_IFU;
    if (ifu_req && lsu_req) begin
      winner = (last_grant == M_IFU) ? M_LSU : M_IFU;
    end else if (lsu_req) begin
      winner = M_LSU;
    end
  end
`else
  // Fixed priority keeps no history, so clock/reset/grant have no loads here.
  logic unused_fixed;
  assign unused_fixed = ^{clk, rst, grant_en, ifu_req};

  // LSU wins whenever it requests; otherwise IFU.
  always_comb begin
    winner = M_IFU;
    if (lsu_req) begin
      winner = M_LSU;
    end
  end
`endif

endmodule

// File: rtl/ysyx_24100029_mem_arbiter.sv
// Two-master (IFU, LSU) to one-slave arbiter in front of the address crossbar.
// One transaction at a time; the granted request is registered toward the
// crossbar and the response is forwarded combinationally to the granted
// master only. Arbitration mode is chosen by YSYX_24100029_ARB_RR_EN
// (see ysyx_24100029_arb_pick).
//
// state        | meaning
// -------------+------------------------------------------------------
// ST_IDLE      | no transaction, xbar_* zero, sampling master requests
// ST_GRANT_IFU | IFU request on xbar, waiting for xbar_resp
// ST_GRANT_LSU | LSU request on xbar, waiting for xbar_resp
module ysyx_24100029_mem_arbiter
  import ysyx_24100029_pkg::*;
(
  input  logic        clk,
  input  logic        rst,

  input  logic [31:0] ifu_addr,
  input  logic [1:0]  ifu_opcode,
  input  logic [2:0]  ifu_size,
  output logic [31:0] ifu_rdata,
  output logic        ifu_resp,

  input  logic [31:0] lsu_addr,
  input  logic [1:0]  lsu_opcode,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wstrb,
  input  logic [2:0]  lsu_size,
  output logic [31:0] lsu_rdata,
  output logic        lsu_resp,

  output logic [31:0] xbar_addr,
  output logic [1:0]  xbar_opcode,
  output logic [31:0] xbar_wdata,
  output logic [3:0]  xbar_wstrb,
  output logic [2:0]  xbar_size,
  input  logic [31:0] xbar_rdata,
  input  logic        xbar_resp
);

  arb_state_e state;
  master_e    winner;
  logic       ifu_req;
  logic       lsu_req;
  logic       grant_en;

  assign ifu_req  = op_valid(ifu_opcode);
  assign lsu_req  = op_valid(lsu_opcode);
  assign grant_en = (state == ST_IDLE) && (ifu_req || lsu_req);

  ysyx_24100029_arb_pick u_pick (
    .clk      (clk),
    .rst      (rst),
    .ifu_req  (ifu_req),
    .lsu_req  (lsu_req),
    .grant_en (grant_en),
    .winner   (winner)
  );

  // Response goes straight through to whoever holds the grant; xbar_resp in
  // IDLE belongs to nobody and is dropped.
  assign ifu_resp  = (state == ST_GRANT_IFU) && xbar_resp;
  assign lsu_resp  = (state == ST_GRANT_LSU) && xbar_resp;
  assign ifu_rdata = ifu_resp ? xbar_rdata : 32'h0;
  assign lsu_rdata = lsu_resp ? xbar_rdata : 32'h0;

  // Grant FSM and request register; the registered xbar_* fields stay frozen
  // for the whole grant, so masters may drop or change their inputs freely.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      xbar_addr   <= 32'h0;
      xbar_opcode <= OP_NONE;
      xbar_wdata  <= 32'h0;
      xbar_wstrb  <= 4'h0;
      xbar_size   <= 3'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_en) begin
            if (winner == M_LSU) begin
              state       <= ST_GRANT_LSU;
              xbar_addr   <= lsu_addr;
              xbar_opcode <= lsu_opcode;
              xbar_wdata  <= lsu_wdata;
              xbar_wstrb  <= lsu_wstrb;
              xbar_size   <= lsu_size;
            end else begin
              // IFU only ever reads; a WRITE opcode from it is issued as READ.
              state       <= ST_GRANT_IFU;
              xbar_addr   <= ifu_addr;
              xbar_opcode <= OP_READ;
              xbar_wdata  <= 32'h0;
              xbar_wstrb  <= 4'h0;
              xbar_size   <= ifu_size;
            end
          end
        end
        ST_GRANT_IFU, ST_GRANT_LSU: begin
          if (xbar_resp) begin
            state       <= ST_IDLE;
            xbar_addr   <= 32'h0;
            xbar_opcode <= OP_NONE;
            xbar_wdata  <= 32'h0;
            xbar_wstrb  <= 4'h0;
            xbar_size   <= 3'h0;
          end
        end
        default: begin
          state       <= ST_IDLE;
          xbar_addr   <= 32'h0;
          xbar_opcode <= OP_NONE;
          xbar_wdata  <= 32'h0;
          xbar_wstrb  <= 4'h0;
          xbar_size   <= 3'h0;
        end
      endcase
    end
  end

endmodule
